// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit saturating counters, plus
// combinational branch/jump misprediction detection and miss statistics.
module branch_predictor #(
   parameter int BTB_INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] pc_IF,
   output logic [15:0] predicted_pc,
   output logic        predict_taken_IF,
   input  logic        stall_IFID,
   input  logic        jump_resolve,
   input  logic [15:0] jump_pc,
   input  logic [15:0] jump_target,
   input  logic [15:0] jump_pred_pc,
   input  logic        branch_resolve,
   input  logic [15:0] branch_pc,
   input  logic [15:0] branch_target,
   input  logic [15:0] branch_pred_pc,
   input  logic        branch_taken,
   output logic        i_branch_miss,
   output logic        jump_miss,
   output logic [15:0] correct_pc,
   output logic [15:0] branch_miss_count,
   output logic [15:0] jump_miss_count
);

   localparam int ENTRIES = 1 << BTB_INDEX_BITS;
   localparam int TAG_W   = 16 - BTB_INDEX_BITS;

   logic               btb_valid   [ENTRIES];
   logic [TAG_W-1:0]   btb_tag     [ENTRIES];
   logic [15:0]        btb_target  [ENTRIES];
   logic [1:0]         btb_ctr     [ENTRIES];
   logic               btb_is_jump [ENTRIES];

   logic [BTB_INDEX_BITS-1:0] if_idx, br_idx, jmp_idx;
   logic [TAG_W-1:0]          if_tag, br_tag, jmp_tag;
   logic                      if_hit, br_hit;
   logic [15:0]               br_next;
   logic                      jump_update;
   logic [1:0]                br_ctr_next;

   assign if_idx  = pc_IF[BTB_INDEX_BITS-1:0];
   assign if_tag  = pc_IF[15:BTB_INDEX_BITS];
   assign br_idx  = branch_pc[BTB_INDEX_BITS-1:0];
   assign br_tag  = branch_pc[15:BTB_INDEX_BITS];
   assign jmp_idx = jump_pc[BTB_INDEX_BITS-1:0];
   assign jmp_tag = jump_pc[15:BTB_INDEX_BITS];

   // IF lookup: reads current contents only, so same-cycle updates are not visible.
   always_comb begin
      if_hit           = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
      predict_taken_IF = if_hit && (btb_is_jump[if_idx] || btb_ctr[if_idx][1]);
      predicted_pc     = predict_taken_IF ? btb_target[if_idx] : pc_IF + 16'd1;
   end

   always_comb begin
      br_next       = branch_taken ? branch_target : branch_pc + 16'd1;
      i_branch_miss = branch_resolve && (br_next != branch_pred_pc);
      // The older branch's miss flushes the jump, so the jump neither reports nor updates.
      jump_update   = jump_resolve && !stall_IFID && !i_branch_miss;
      jump_miss     = jump_update && (jump_target != jump_pred_pc);
      if (i_branch_miss)
         correct_pc = br_next;
      else if (jump_miss)
         correct_pc = jump_target;
      else
         correct_pc = 16'h0000;
   end

   always_comb begin
      br_hit      = btb_valid[br_idx] && (btb_tag[br_idx] == br_tag);
      br_ctr_next = btb_ctr[br_idx];
      if (branch_taken) begin
         if (btb_ctr[br_idx] != 2'b11)
            br_ctr_next = btb_ctr[br_idx] + 2'b01;
      end else begin
         if (btb_ctr[br_idx] != 2'b00)
            br_ctr_next = btb_ctr[br_idx] - 2'b01;
      end
   end

   // The jump write comes after the branch write so it wins on a shared index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_valid[i]   <= 1'b0;
            btb_tag[i]     <= '0;
            btb_target[i]  <= 16'h0000;
            btb_ctr[i]     <= 2'b01;
            btb_is_jump[i] <= 1'b0;
         end
      end else begin
         if (branch_resolve) begin
            if (br_hit) begin
               btb_ctr[br_idx]     <= br_ctr_next;
               btb_is_jump[br_idx] <= 1'b0;
               if (branch_taken)
                  btb_target[br_idx] <= branch_target;
            end else if (branch_taken) begin
               btb_valid[br_idx]   <= 1'b1;
               btb_tag[br_idx]     <= br_tag;
               btb_target[br_idx]  <= branch_target;
               btb_ctr[br_idx]     <= 2'b10;
               btb_is_jump[br_idx] <= 1'b0;
            end
         end
         if (jump_update) begin
            btb_valid[jmp_idx]   <= 1'b1;
            btb_tag[jmp_idx]     <= jmp_tag;
            btb_target[jmp_idx]  <= jump_target;
            btb_ctr[jmp_idx]     <= 2'b11;
            btb_is_jump[jmp_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         branch_miss_count <= 16'h0000;
         jump_miss_count   <= 16'h0000;
      end else begin
         if (i_branch_miss && (branch_miss_count != 16'hFFFF))
            branch_miss_count <= branch_miss_count + 16'd1;
         if (jump_miss && (jump_miss_count != 16'hFFFF))
            jump_miss_count <= jump_miss_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, counter hysteresis, jump/branch
// miss priority, same-index write ordering, aliasing and asynchronous reset.
module tb_branch_predictor;

   logic        clk;
   logic        reset_n;
   logic [15:0] pc_IF;
   logic [15:0] predicted_pc;
   logic        predict_taken_IF;
   logic        stall_IFID;
   logic        jump_resolve;
   logic [15:0] jump_pc, jump_target, jump_pred_pc;
   logic        branch_resolve;
   logic [15:0] branch_pc, branch_target, branch_pred_pc;
   logic        branch_taken;
   logic        i_branch_miss;
   logic        jump_miss;
   logic [15:0] correct_pc;
   logic [15:0] branch_miss_count, jump_miss_count;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(.BTB_INDEX_BITS(4)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .pc_IF             (pc_IF),
      .predicted_pc      (predicted_pc),
      .predict_taken_IF  (predict_taken_IF),
      .stall_IFID        (stall_IFID),
      .jump_resolve      (jump_resolve),
      .jump_pc           (jump_pc),
      .jump_target       (jump_target),
      .jump_pred_pc      (jump_pred_pc),
      .branch_resolve    (branch_resolve),
      .branch_pc         (branch_pc),
      .branch_target     (branch_target),
      .branch_pred_pc    (branch_pred_pc),
      .branch_taken      (branch_taken),
      .i_branch_miss     (i_branch_miss),
      .jump_miss         (jump_miss),
      .correct_pc        (correct_pc),
      .branch_miss_count (branch_miss_count),
      .jump_miss_count   (jump_miss_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag_s, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag_s, obs, exp);
      end
   endtask

   // driver tasks: drive just after the rising edge, sample combinational outputs #1 later
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall_IFID     = 1'b0;
      jump_resolve   = 1'b0;
      jump_pc        = 16'h0;
      jump_target    = 16'h0;
      jump_pred_pc   = 16'h0;
      branch_resolve = 1'b0;
      branch_pc      = 16'h0;
      branch_target  = 16'h0;
      branch_pred_pc = 16'h0;
      branch_taken   = 1'b0;
   endtask

   task automatic drive_branch(input logic [15:0] pc, input logic [15:0] tgt,
                               input logic [15:0] pred, input logic taken);
      branch_resolve = 1'b1;
      branch_pc      = pc;
      branch_target  = tgt;
      branch_pred_pc = pred;
      branch_taken   = taken;
   endtask

   task automatic drive_jump(input logic [15:0] pc, input logic [15:0] tgt,
                             input logic [15:0] pred, input logic stall);
      jump_resolve = 1'b1;
      jump_pc      = pc;
      jump_target  = tgt;
      jump_pred_pc = pred;
      stall_IFID   = stall;
   endtask

   task automatic lookup(input string tag_s, input logic [15:0] pc,
                         input logic [15:0] exp_pc, input logic exp_taken);
      pc_IF = pc;
      #1;
      check({tag_s, "_pc"}, predicted_pc, exp_pc);
      check({tag_s, "_tk"}, {15'd0, predict_taken_IF}, {15'd0, exp_taken});
   endtask

   task automatic taken_resolve_no_miss(input string tag_s);
      drive_branch(16'h0020, 16'h0030, 16'h0030, 1'b1);
      #1;
      check(tag_s, {15'd0, i_branch_miss}, 16'd0);
      next_cycle();
      idle_inputs();
   endtask

   initial begin
      reset_n = 1'b0;
      pc_IF   = 16'h0010;
      idle_inputs();
      #2;
      check("rst_bcnt", branch_miss_count, 16'h0);
      check("rst_jcnt", jump_miss_count, 16'h0);
      check("rst_cpc", correct_pc, 16'h0);
      check("rst_bmiss", {15'd0, i_branch_miss}, 16'd0);
      check("rst_jmiss", {15'd0, jump_miss}, 16'd0);
      lookup("rst_0010", 16'h0010, 16'h0011, 1'b0);
      lookup("rst_wrap", 16'hFFFF, 16'h0000, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      next_cycle();

      // taken branch at 0x0020 that was predicted fall-through
      drive_branch(16'h0020, 16'h0030, 16'h0021, 1'b1);
      #1;
      check("br1_miss", {15'd0, i_branch_miss}, 16'd1);
      check("br1_cpc", correct_pc, 16'h0030);
      check("br1_jmiss", {15'd0, jump_miss}, 16'd0);
      lookup("br1_same_cycle", 16'h0020, 16'h0021, 1'b0);
      next_cycle();
      idle_inputs();
      check("br1_cnt", branch_miss_count, 16'd1);
      lookup("br1_alloc", 16'h0020, 16'h0030, 1'b1);
      lookup("alias", 16'h0030, 16'h0031, 1'b0);

      // hysteresis: ctr 2 -> 3 -> 3, then two not-taken steps
      taken_resolve_no_miss("hyst_t1");
      taken_resolve_no_miss("hyst_t2");
      drive_branch(16'h0020, 16'h0030, 16'h0030, 1'b0);
      #1;
      check("hyst_nt1_miss", {15'd0, i_branch_miss}, 16'd1);
      check("hyst_nt1_cpc", correct_pc, 16'h0021);
      next_cycle();
      idle_inputs();
      lookup("hyst_nt1", 16'h0020, 16'h0030, 1'b1);
      drive_branch(16'h0020, 16'h0030, 16'h0030, 1'b0);
      next_cycle();
      idle_inputs();
      lookup("hyst_nt2", 16'h0020, 16'h0021, 1'b0);
      check("hyst_cnt", branch_miss_count, 16'd3);

      // not-taken branch at 0xFFFF falls through to 0x0000
      drive_branch(16'hFFFF, 16'h1234, 16'h0000, 1'b0);
      #1;
      check("wrap_br_miss", {15'd0, i_branch_miss}, 16'd0);
      next_cycle();
      idle_inputs();

      // jump under stall: no miss and no allocation
      drive_jump(16'h0040, 16'h0100, 16'h0041, 1'b1);
      #1;
      check("jstall_miss", {15'd0, jump_miss}, 16'd0);
      check("jstall_cpc", correct_pc, 16'h0);
      next_cycle();
      idle_inputs();
      lookup("jstall_noalloc", 16'h0040, 16'h0041, 1'b0);
      check("jstall_cnt", jump_miss_count, 16'd0);

      drive_jump(16'h0040, 16'h0100, 16'h0041, 1'b0);
      #1;
      check("j1_miss", {15'd0, jump_miss}, 16'd1);
      check("j1_cpc", correct_pc, 16'h0100);
      next_cycle();
      idle_inputs();
      check("j1_cnt", jump_miss_count, 16'd1);
      lookup("j1_alloc", 16'h0040, 16'h0100, 1'b1);
      lookup("j1_evict", 16'h0020, 16'h0021, 1'b0);

      // simultaneous branch miss and jump miss: branch wins, jump squashed
      drive_branch(16'h0060, 16'h0050, 16'h0061, 1'b1);
      drive_jump(16'h0071, 16'h0200, 16'h0072, 1'b0);
      #1;
      check("sim_bmiss", {15'd0, i_branch_miss}, 16'd1);
      check("sim_jmiss", {15'd0, jump_miss}, 16'd0);
      check("sim_cpc", correct_pc, 16'h0050);
      next_cycle();
      idle_inputs();
      check("sim_jcnt", jump_miss_count, 16'd1);
      check("sim_bcnt", branch_miss_count, 16'd4);
      lookup("sim_nojw", 16'h0071, 16'h0072, 1'b0);
      lookup("sim_bralloc", 16'h0060, 16'h0050, 1'b1);

      // branch and jump on the same index, no branch miss: jump entry wins
      drive_branch(16'h0080, 16'h00A0, 16'h00A0, 1'b1);
      drive_jump(16'h0090, 16'h0300, 16'h0091, 1'b0);
      #1;
      check("same_bmiss", {15'd0, i_branch_miss}, 16'd0);
      check("same_jmiss", {15'd0, jump_miss}, 16'd1);
      next_cycle();
      idle_inputs();
      lookup("same_jwin", 16'h0090, 16'h0300, 1'b1);
      lookup("same_blose", 16'h0080, 16'h0081, 1'b0);
      check("same_jcnt", jump_miss_count, 16'd2);

      // asynchronous reset mid-cycle
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_bcnt", branch_miss_count, 16'h0);
      check("arst_jcnt", jump_miss_count, 16'h0);
      lookup("arst_j", 16'h0090, 16'h0091, 1'b0);
      lookup("arst_b", 16'h0060, 16'h0061, 1'b0);
      check("arst_cpc", correct_pc, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
